// File: rtl/store_write_buffer_pkg.sv
// rtl/store_write_buffer_pkg.sv - shared constants and helpers for the store write buffer
package store_write_buffer_pkg;

  // Stores are word-only: address bits below this index select a byte within a word.
  localparam int WORD_LSB = 2;

  // Pointer width for a power-of-two depth (ceil(log2(depth))).
  function automatic int swb_ptr_w(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/swb_fwd_match.sv
// rtl/swb_fwd_match.sv - newest-entry word-address match for load forwarding
module swb_fwd_match
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WAW   = 30,
  parameter int DW    = 32,
  parameter int PTR_W = 2
) (
  input  logic [DEPTH*WAW-1:0] i_adr_word,
  input  logic [DEPTH*DW-1:0]  i_data,
  input  logic [DEPTH-1:0]     i_valid,
  input  logic [PTR_W-1:0]     i_wr_ptr,
  input  logic [WAW-1:0]       i_rd_word,
  output logic                 o_hit,
  output logic [PTR_W-1:0]     o_idx,
  output logic [DW-1:0]        o_data
);

  logic [PTR_W-1:0] w_idx;

  // Walk from the oldest slot (wr_ptr-DEPTH) to the newest (wr_ptr-1); later matches overwrite earlier ones so the newest wins.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    o_data = '0;
    w_idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_idx = i_wr_ptr - PTR_W'(k);
      if (i_valid[w_idx] && (i_adr_word[w_idx*WAW +: WAW] == i_rd_word)) begin
        o_hit  = 1'b1;
        o_idx  = w_idx;
        o_data = i_data[w_idx*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - core store FIFO draining to memory with load forwarding
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        MemWrite,
  input  logic [AW-1:0]               dataadr,
  input  logic [DW-1:0]               WriteData,
  output logic                        stall,
  input  logic [AW-1:0]               rd_adr,
  output logic                        rd_hit,
  output logic [DW-1:0]               rd_data,
  output logic                        mem_valid,
  output logic [AW-1:0]               mem_adr,
  output logic [DW-1:0]               mem_wdata,
  input  logic                        mem_ready,
  output logic [swb_ptr_w(DEPTH):0]   count,
  output logic                        empty
);

  localparam int PTR_W = swb_ptr_w(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int WAW   = AW - WORD_LSB;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t           r_entry [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic [DEPTH-1:0]     w_valid;
  logic [DEPTH*WAW-1:0] w_adr_word;
  logic [DEPTH*DW-1:0]  w_data_flat;
  logic [PTR_W-1:0]     w_fwd_idx;
  logic                 w_unused_bits;

  // Handshake decode: a full buffer refuses the store even if the head drains this cycle.
  always_comb begin
    w_full    = (r_count == CW'(DEPTH));
    empty     = (r_count == '0);
    mem_valid = ~empty;
    stall     = MemWrite & w_full;
    w_push    = MemWrite & ~w_full;
    w_pop     = mem_valid & mem_ready;
    mem_adr   = r_entry[r_rd_ptr].adr;
    mem_wdata = r_entry[r_rd_ptr].data;
    count     = r_count;
  end

  // FIFO state: entries, wrapping pointers and occupancy, all cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_entry[r_wr_ptr] <= '{adr: dataadr, data: WriteData};
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Occupied-slot mask (age from rd_ptr below count) and flattened word addresses/data for the matcher.
  always_comb begin
    w_valid     = '0;
    w_adr_word  = '0;
    w_data_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i]                 = ({1'b0, PTR_W'(i) - r_rd_ptr} < r_count);
      w_adr_word[i*WAW +: WAW]   = r_entry[i].adr[AW-1:WORD_LSB];
      w_data_flat[i*DW +: DW]    = r_entry[i].data;
    end
  end

  swb_fwd_match #(
    .DEPTH (DEPTH),
    .WAW   (WAW),
    .DW    (DW),
    .PTR_W (PTR_W)
  ) u_fwd (
    .i_adr_word (w_adr_word),
    .i_data     (w_data_flat),
    .i_valid    (w_valid),
    .i_wr_ptr   (r_wr_ptr),
    .i_rd_word  (rd_adr[AW-1:WORD_LSB]),
    .o_hit      (rd_hit),
    .o_idx      (w_fwd_idx),
    .o_data     (rd_data)
  );

  // Byte-offset bits of the load address and the match index are not needed here.
  assign w_unused_bits = ^{rd_adr[WORD_LSB-1:0], w_fwd_idx};

endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - table-driven, scoreboarded bench for store_write_buffer
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          MemWrite = 1'b0;
  logic [AW-1:0] dataadr = '0;
  logic [DW-1:0] WriteData = '0;
  logic          stall;
  logic [AW-1:0] rd_adr = '0;
  logic          rd_hit;
  logic [DW-1:0] rd_data;
  logic          mem_valid;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [2:0]    count;
  logic          empty;

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .dataadr   (dataadr),
    .WriteData (WriteData),
    .stall     (stall),
    .rd_adr    (rd_adr),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data),
    .mem_valid (mem_valid),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .count     (count),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          mw;
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
    logic          rdy;
    logic [AW-1:0] ra;
    logic          e_stall;
    logic          e_hit;
    logic [DW-1:0] e_rd;
    int            e_cnt;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
  } sb_t;

  vec_t vt[$];
  sb_t  sb_q[$];
  int   m_count = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic mw, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rdy,
                     input logic [AW-1:0] ra, input logic es, input logic eh, input logic [DW-1:0] er, input int ec);
    vec_t v;
    v.mw = mw; v.adr = a; v.data = d; v.rdy = rdy; v.ra = ra;
    v.e_stall = es; v.e_hit = eh; v.e_rd = er; v.e_cnt = ec;
    vt.push_back(v);
  endtask

  // One clock cycle: drive at posedge+1, check combinational outputs mid-cycle, check state after the edge.
  task automatic run_vec(input vec_t v, input string tag, input bit use_tbl);
    bit m_full, m_push, m_pop;
    MemWrite = v.mw; dataadr = v.adr; WriteData = v.data; mem_ready = v.rdy; rd_adr = v.ra;
    #3;
    m_full = (m_count == DEPTH);
    m_push = v.mw && !m_full;
    m_pop  = (m_count > 0) && v.rdy;
    if (use_tbl) begin
      chk({tag, " stall"}, stall, v.e_stall);
      chk({tag, " rd_hit"}, rd_hit, v.e_hit);
      chk({tag, " rd_data"}, rd_data, v.e_rd);
    end
    chk({tag, " mem_valid"}, mem_valid, (m_count > 0));
    if (m_pop) begin
      chk({tag, " mem_adr"}, mem_adr, sb_q[0].adr);
      chk({tag, " mem_wdata"}, mem_wdata, sb_q[0].data);
      void'(sb_q.pop_front());
    end
    if (m_push) sb_q.push_back('{adr: v.adr, data: v.data});
    m_count = m_count + int'(m_push) - int'(m_pop);
    @(posedge clk);
    #1;
    chk({tag, " count"}, count, m_count);
    chk({tag, " empty"}, empty, (m_count == 0));
    if (use_tbl) chk({tag, " count_tbl"}, count, v.e_cnt);
  endtask

  task automatic idle(input logic mw, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rdy, input string tag);
    vec_t v;
    v.mw = mw; v.adr = a; v.data = d; v.rdy = rdy; v.ra = '0;
    v.e_stall = 1'b0; v.e_hit = 1'b0; v.e_rd = '0; v.e_cnt = 0;
    run_vec(v, tag, 1'b0);
  endtask

  initial begin
    // Single store then drain (popped entry still forwards in its pop cycle).
    add(1, 32'h50, 32'h7, 0, 32'h0,  0, 0, 32'h0, 1);
    add(0, 32'h0,  32'h0, 1, 32'h50, 0, 1, 32'h7, 0);
    // Fill to full, stall, drain one while core holds the store, retry.
    add(1, 32'h10, 32'hA1, 0, 32'h0, 0, 0, 32'h0, 1);
    add(1, 32'h14, 32'hA2, 0, 32'h0, 0, 0, 32'h0, 2);
    add(1, 32'h18, 32'hA3, 0, 32'h0, 0, 0, 32'h0, 3);
    add(1, 32'h1C, 32'hA4, 0, 32'h0, 0, 0, 32'h0, 4);
    add(1, 32'h20, 32'hA5, 0, 32'h0, 1, 0, 32'h0, 4);
    add(1, 32'h20, 32'hA5, 1, 32'h0, 1, 0, 32'h0, 3);
    add(1, 32'h20, 32'hA5, 0, 32'h0, 0, 0, 32'h0, 4);
    add(0, 32'h0, 32'h0, 1, 32'h0, 0, 0, 32'h0, 3);
    add(0, 32'h0, 32'h0, 1, 32'h0, 0, 0, 32'h0, 2);
    add(0, 32'h0, 32'h0, 1, 32'h0, 0, 0, 32'h0, 1);
    add(0, 32'h0, 32'h0, 1, 32'h0, 0, 0, 32'h0, 0);
    // Forwarding: same-cycle push not forwarded; newest of two matches wins; byte offset ignored.
    add(1, 32'h54, 32'h19, 0, 32'h54, 0, 0, 32'h0,  1);
    add(1, 32'h54, 32'h1A, 0, 32'h54, 0, 1, 32'h19, 2);
    add(0, 32'h0,  32'h0,  0, 32'h54, 0, 1, 32'h1A, 2);
    add(0, 32'h0,  32'h0,  0, 32'h56, 0, 1, 32'h1A, 2);
    add(0, 32'h0,  32'h0,  0, 32'h58, 0, 0, 32'h0,  2);
    // Simultaneous push/pop at count 2 across pointer wrap.
    for (int k = 1; k <= 10; k++) add(1, 32'h100 + 32'(4 * k), 32'(k), 1, 32'h0, 0, 0, 32'h0, 2);
    add(0, 32'h0, 32'h0, 1, 32'h0, 0, 0, 32'h0, 1);
    add(0, 32'h0, 32'h0, 1, 32'h0, 0, 0, 32'h0, 0);

    // Reset held with a store presented.
    reset = 1'b0; MemWrite = 1'b1; dataadr = 32'h99; WriteData = 32'h55; mem_ready = 1'b1; rd_adr = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst count", count, 0);
    chk("rst mem_valid", mem_valid, 0);
    chk("rst stall", stall, 0);
    chk("rst empty", empty, 1);
    chk("rst mem_adr", mem_adr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst rd_hit", rd_hit, 0);
    chk("rst rd_data", rd_data, 0);
    MemWrite = 1'b0; mem_ready = 1'b0; reset = 1'b1;
    idle(0, 0, 0, 0, "post_rst0");
    idle(0, 0, 0, 1, "post_rst1");

    foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i), 1'b1);

    // Reset mid-drain: pending entries must vanish immediately and never reach memory.
    idle(1, 32'h200, 32'hB0, 0, "md_push0");
    idle(1, 32'h204, 32'hB1, 0, "md_push1");
    idle(1, 32'h208, 32'hB2, 0, "md_push2");
    MemWrite = 1'b0; mem_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("md mem_valid", mem_valid, 0);
    chk("md count", count, 0);
    chk("md empty", empty, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    sb_q.delete();
    m_count = 0;
    idle(0, 0, 0, 1, "md_after0");
    idle(0, 0, 0, 1, "md_after1");
    idle(1, 32'h300, 32'hAB, 0, "md_new_push");
    idle(0, 0, 0, 1, "md_new_drain");
    idle(0, 0, 0, 1, "md_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Sits directly downstream of the single-cycle RISC-V core. Consumes the core's store stream (MemWrite, dataadr, WriteData) and drains it to data memory over a valid/ready handshake.
- Lets the core retire sw instructions without waiting on a slow memory port.
- Forwards buffered store data to core loads (lw) so a load never reads stale memory.
- Stores are word-only; byte-enables are out of scope.

Parameters:
DEPTH, 4, number of buffered stores; power of two, >= 2
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
MemWrite  in  1  core store strobe, one store per cycle when high
dataadr  in  AW  core store address
WriteData  in  DW  core store data
stall  out  1  core must hold the current store; equals MemWrite & full
rd_adr  in  AW  core load address for forwarding lookup
rd_hit  out  1  a buffered entry matches rd_adr
rd_data  out  DW  data of the newest matching entry
mem_valid  out  1  head entry is presented to memory
mem_adr  out  AW  head entry address
mem_wdata  out  DW  head entry data
mem_ready  in  1  memory accepts the head entry this cycle
count  out  log2(DEPTH)+1  number of occupied entries
empty  out  1  count == 0

Behaviour:
- Reset
  - reset low immediately clears count, read/write pointers and all entry registers (asynchronous).
  - Resulting outputs: mem_valid=0, mem_adr=0, mem_wdata=0, count=0, empty=1, rd_hit=0, rd_data=0, stall=0.
  - Reset mid-operation discards all pending stores; nothing is drained after release.
- Storage and state
  - Circular FIFO of DEPTH entries {adr, data}.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is held as a separate register.
  - full = (count == DEPTH).
- Push
  - Occurs on a rising edge when MemWrite=1 and full=0: entry[wr_ptr] <= {dataadr, WriteData}, then wr_ptr+1.
  - When full, no push happens, even if a pop occurs in the same cycle. The core holds the store while stall=1 and retries next cycle.
  - stall is combinational, with zero cycles of latency.
- Pop
  - mem_valid = ~empty. mem_adr and mem_wdata are combinational from entry[rd_ptr].
  - The pop occurs on a rising edge when mem_valid & mem_ready: rd_ptr+1.
  - mem_ready while empty is ignored.
  - Once asserted, the head entry stays stable until it is accepted.
- Count update
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
  - Never exceeds DEPTH and never goes below 0.
- Latency
  - A store accepted at edge N is visible on mem_* after edge N if the buffer was empty.
  - Minimum residency is one cycle; there is no bypass from core to memory.
- Ordering: strict FIFO; memory sees stores in program order.
- Forwarding
  - Purely combinational.
  - Compares the word address rd_adr[AW-1:2] against the word address adr[AW-1:2] of every valid entry.
  - The newest valid match wins, searched from wr_ptr-1 back to rd_ptr.
  - No match gives rd_hit=0 and rd_data=0.
  - A store being pushed in the same cycle is not forwarded.
  - An entry being popped in the same cycle still forwards.

Decomposition:
- Shared package holds:
  - entry struct/typedef {adr[AW-1:0], data[DW-1:0]}
  - WORD_LSB=2 constant
  - ptr-width function clog2(DEPTH)
- One natural sub-module: swb_fwd_match. It takes the entry array, valid mask, pointers and rd_adr, and returns the newest-match index, hit and data.
- FIFO control stays in the top.

Test Plan:
- Reset: hold reset=0 with MemWrite=1 -> count=0, mem_valid=0, stall=0. Release reset with no store -> empty=1 persists.
- Single store: MemWrite=1, dataadr=0x50, WriteData=0x7, mem_ready=0 -> next cycle mem_valid=1, mem_adr=0x50, mem_wdata=0x7, count=1. Then mem_ready=1 for one cycle -> count=0, mem_valid=0.
- Full and stall:
  - With mem_ready=0, store 0x10, 0x14, 0x18, 0x1C -> count=4.
  - A 5th store to 0x20 -> stall=1 and it is not enqueued.
  - Pulse mem_ready=1 -> 0x10 is drained, count=3, stall=0.
  - Retry 0x20 -> accepted, count=4.
- Forwarding:
  - Store 0x54←0x19, then 0x54←0x1A, with mem_ready=0.
  - rd_adr=0x54 -> rd_hit=1, rd_data=0x1A.
  - rd_adr=0x56 -> rd_hit=1, rd_data=0x1A (same word).
  - rd_adr=0x58 -> rd_hit=0, rd_data=0.
- Simultaneous push/pop and wrap: at count=2, MemWrite=1 and mem_ready=1 for 10 consecutive cycles with data 1..10 -> count stays 2 throughout, and memory receives the stores in exact program order across pointer wrap.
- Reset mid-drain: with 3 entries pending, drop reset for one cycle -> mem_valid=0 immediately, count=0, and none of the old entries appear after release.
